// File: rtl/flags_drain_controller.sv
// flags_drain_controller
//   Drains the flags register file. It scans the per-channel RX flags, picks
//   one pending channel round-robin, and offers its address over a
//   valid/ready handshake. After the consumer accepts, it clears the flag with
//   a one-cycle RTR write strobe, then idles one cycle so the register file
//   update is visible before the next scan.
//
//   Optional build macro: FLAGS_DRAIN_TIMEOUT_EN
//     When defined, an offer that waits TIMEOUT_CYCLES without acceptance is
//     abandoned. The flag is not cleared, the sticky timeout_error output is
//     set, and the round-robin pointer moves past the abandoned channel.
module flags_drain_controller #(
  parameter int ADDR_WIDTH = 1
`ifdef FLAGS_DRAIN_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [2**ADDR_WIDTH-1:0] flags_in,
  output logic                     req_valid,
  output logic [ADDR_WIDTH-1:0]    req_address,
  input  logic                     req_ready,
  output logic                     rtr_write_enable,
  output logic [ADDR_WIDTH-1:0]    rtr_address,
  output logic                     busy
`ifdef FLAGS_DRAIN_TIMEOUT_EN
  , output logic                   timeout_error
`endif
);

  localparam int NUM_FLAGS = 2**ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    CLEAR,
    SETTLE
  } state_t;

  state_t                  state_reg;
  logic [ADDR_WIDTH-1:0]   rr_pointer_reg;
  logic [ADDR_WIDTH-1:0]   pick_next;
  logic [ADDR_WIDTH-1:0]   scan_idx;
  logic                    pick_valid;

`ifdef FLAGS_DRAIN_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]        wait_cnt_reg;
`endif

  // Round-robin pick: the first set flag at or above rr_pointer, wrapping.
  // Scanning from the farthest offset down lets the nearest hit win.
  always_comb begin
    pick_valid = |flags_in;
    pick_next  = rr_pointer_reg;
    scan_idx   = rr_pointer_reg;
    for (int i = NUM_FLAGS - 1; i >= 0; i--) begin
      scan_idx = rr_pointer_reg + ADDR_WIDTH'(i);
      if (flags_in[scan_idx]) begin
        pick_next = scan_idx;
      end
    end
  end

  // Handshake FSM; every output is registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      req_valid        <= 1'b0;
      req_address      <= '0;
      rtr_write_enable <= 1'b0;
      rtr_address      <= '0;
      busy             <= 1'b0;
      rr_pointer_reg   <= '0;
`ifdef FLAGS_DRAIN_TIMEOUT_EN
      wait_cnt_reg     <= '0;
      timeout_error    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          rtr_write_enable <= 1'b0;
          if (pick_valid) begin
            req_address <= pick_next;
            req_valid   <= 1'b1;
            busy        <= 1'b1;
            state_reg   <= OFFER;
`ifdef FLAGS_DRAIN_TIMEOUT_EN
            wait_cnt_reg <= '0;
`endif
          end
        end
        OFFER: begin
          // req_valid is known to be high here, so req_ready alone means accept.
          if (req_ready) begin
            req_valid        <= 1'b0;
            rtr_write_enable <= 1'b1;
            rtr_address      <= req_address;
            state_reg        <= CLEAR;
          end
`ifdef FLAGS_DRAIN_TIMEOUT_EN
          else if (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // Abandon: the flag stays pending, so skip past it for fairness.
            req_valid      <= 1'b0;
            timeout_error  <= 1'b1;
            rr_pointer_reg <= req_address + ADDR_WIDTH'(1);
            state_reg      <= SETTLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
          end
`endif
        end
        CLEAR: begin
          rtr_write_enable <= 1'b0;
          rr_pointer_reg   <= req_address + ADDR_WIDTH'(1);
          state_reg        <= SETTLE;
        end
        SETTLE: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/flags_drain_controller.md
Name: flags_drain_controller

Overview:
- Consumer end of the flags register file: scans per-channel RX flags, picks one pending channel round-robin, and hands its address to the transmit/processing side over a valid/ready handshake.
- Once accepted, it clears that flag by pulsing the register file's RTR write port with the channel address.
- Sits between the flags register file and the gpp_txrx core datapath.

Parameters:
- ADDR_WIDTH, 1, flag address width; NUM_FLAGS = 2**ADDR_WIDTH.
- TIMEOUT_CYCLES, 16, cycles to wait for req_ready before abandoning a request. Used only with FLAGS_DRAIN_TIMEOUT_EN.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- flags_in  input  NUM_FLAGS  current flag bits from the register file; 1 = data received, pending.
- req_valid  output  1  pending channel offered to consumer.
- req_address  output  ADDR_WIDTH  channel address offered; stable while req_valid=1.
- req_ready  input  1  consumer accepts when req_valid && req_ready at a clock edge.
- rtr_write_enable  output  1  one-cycle clear strobe to the register file.
- rtr_address  output  ADDR_WIDTH  address cleared; valid when rtr_write_enable=1.
- busy  output  1  FSM not in IDLE.
- timeout_error  output  1  sticky; exists only with FLAGS_DRAIN_TIMEOUT_EN.

Behaviour:
- Reset (async assert, sync release): state=IDLE. req_valid=0, req_address=0, rtr_write_enable=0, rtr_address=0, busy=0, rr_pointer=0, timeout_error=0.
- Reset asserted mid-handshake aborts immediately. No clear strobe is issued; the flag stays set in the register file.
- FSM states: IDLE, OFFER, CLEAR, SETTLE.
- IDLE: if any flags_in bit is 1, choose the first set bit scanning from rr_pointer upward with wrap (NUM_FLAGS-1 -> 0).
  - Register the choice into req_address and go to OFFER.
  - req_valid rises the cycle after the flag is seen (1-cycle latency).
- OFFER: req_valid=1 and req_address held constant.
  - req_valid && req_ready at an edge -> CLEAR.
  - req_ready asserted the same cycle req_valid first rises is accepted (zero-wait).
  - req_valid is never withdrawn without acceptance, except on timeout (optional feature).
- CLEAR: exactly one cycle with rtr_write_enable=1, rtr_address=req_address, req_valid=0.
  - rr_pointer <= req_address+1, modulo NUM_FLAGS.
  - Next state SETTLE.
- SETTLE: one idle cycle so the register file update is visible on flags_in before the next scan (prevents double-issue of a just-cleared flag). Next state IDLE.
- Throughput: at most one flag per 4 cycles with req_ready tied high.
- flags_in changing during OFFER does not affect req_address.
- A flag that drops before acceptance is still offered and cleared (clearing an already-clear flag is harmless).
- Fairness: a channel set continuously is served at most once per NUM_FLAGS grants while others are pending.
- busy=1 in OFFER, CLEAR, SETTLE.

Optional Feature:
- Macro: FLAGS_DRAIN_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) counts OFFER cycles without acceptance.
  - On reaching TIMEOUT_CYCLES: drop req_valid, set timeout_error=1 (sticky until reset), advance rr_pointer past the abandoned channel, go to SETTLE.
  - No clear strobe is issued, so the flag stays pending and is re-offered later.
  - Counter resets on entry to OFFER.
- Undefined: no counter and no timeout_error port. OFFER waits indefinitely.

Test Plan:
- Reset, then flags_in=2'b01, req_ready=1: req_valid=1 with req_address=0 one cycle later. Next cycle rtr_write_enable=1, rtr_address=0. busy returns to 0 after SETTLE.
- flags_in=2'b11 held, req_ready=1: grants alternate 0,1,0,1. Each grant is followed by exactly one rtr_write_enable pulse at the matching address.
- flags_in=2'b10, req_ready held 0 for 5 cycles, then 1: req_valid and req_address=1 stay stable for all 5 cycles. Single clear of address 1 after acceptance.
- Change flags_in from 2'b01 to 2'b10 while in OFFER: req_address stays 0 and the clear targets 0. Channel 1 is offered next.
- reset_n pulled low during OFFER: all outputs go 0 asynchronously with no rtr_write_enable pulse. After release, the pending flag is re-offered starting from rr_pointer=0.
- FLAGS_DRAIN_TIMEOUT_EN with TIMEOUT_CYCLES=4, flags_in=2'b01, req_ready=0: req_valid drops after 4 cycles, timeout_error=1 and stays 1, no clear pulse, channel 0 re-offered afterwards.
